// File: rtl/hub_link_pkg.sv
// hub_link_pkg
//   Definitions shared by the receive and transmit ends of the narrow hub link:
//   - calc_beats(): number of narrow beats that make up one wide hub word
//   - LSB_FIRST: beat order on the narrow channel (beat 0 carries the low bits)
//   - credit_cnt_t: credit counter type, wide enough to hold 0..CREDITS
//     inclusive for the default link depth.
package hub_link_pkg;

    localparam bit LSB_FIRST        = 1'b1;
    localparam int HUB_LINK_CREDITS = 4;

    typedef logic [$clog2(HUB_LINK_CREDITS):0] credit_cnt_t;

    function automatic int calc_beats(input int wide_w, input int phys_w);
        return wide_w / phys_w;
    endfunction

endpackage

// File: rtl/hub_link_rx_buf.sv
// hub_link_rx_buf
//   DEPTH-entry first-word-fall-through buffer for reassembled hub words.
//   The head word is presented combinationally and reads as zero when the
//   buffer is empty. A push is taken when there is room or when a pop happens
//   on the same edge. A push into a full buffer with no pop is ignored; the
//   caller flags that case.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   push/push_data write request and word
//   pop            remove the head word (ignored when empty)
//   head_data      current head word
//   full           DEPTH words held
//   count          occupancy, 0..DEPTH
module hub_link_rx_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // When full, the slot being written is the one being popped this edge;
    // its old contents have already been consumed from head_data.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
        else if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/hub_link_rx.sv
// hub_link_rx
//   Receive end of the credit-based narrow hub link. Narrow beats (LSB beat
//   first) are assembled into wide words, queued in a CREDITS-deep FWFT
//   buffer, and one credit_return pulse is produced for every word drained.
//   The narrow side has no ready: credits guarantee room, and a word arriving
//   to a full buffer is dropped and flagged with overflow_err.
// Optional feature (macro HUB_LINK_PARITY_EN): adds narrow_parity (even parity
//   over narrow_data) and sets parity_err on a mismatch; without it
//   parity_err is tied low.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   narrow_valid/narrow_data  incoming beat
//   narrow_parity             beat parity (HUB_LINK_PARITY_EN only)
//   wide_valid/ready/data     FWFT word output to the hub
//   credit_return             one-cycle pulse per drained word
//   overflow_err, parity_err  sticky error flags
module hub_link_rx
    import hub_link_pkg::*;
#(
    parameter int HUB_FIFO_WIDTH          = 32,
    parameter int HUB_FIFO_PHYSICAL_WIDTH = 4,
    parameter int CREDITS                 = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               narrow_valid,
    input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] narrow_data,
`ifdef HUB_LINK_PARITY_EN
    input  logic                               narrow_parity,
`endif
    output logic                               wide_valid,
    input  logic                               wide_ready,
    output logic [HUB_FIFO_WIDTH-1:0]          wide_data,
    output logic                               credit_return,
    output logic                               overflow_err,
    output logic                               parity_err
);

    localparam int W     = HUB_FIFO_WIDTH;
    localparam int P     = HUB_FIFO_PHYSICAL_WIDTH;
    localparam int BEATS = calc_beats(W, P);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic             rx_en_q, rx_en_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [W-1:0]     shift_q, shift_d;
    logic             credit_return_q, credit_return_d;
    logic             overflow_err_q, overflow_err_d;

    logic             beat_acc;
    logic             last_beat;
    logic [W-1:0]     assembled;
    logic             pop;
    logic             buf_full;
    logic [$clog2(CREDITS):0] buf_count;

    // Reset release is re-timed through rx_en_q: beats are ignored on the
    // first edge after release and accepted from the second edge on.
    assign beat_acc  = narrow_valid && rx_en_q;
    assign last_beat = beat_acc && (beat_cnt_q == CNT_W'(BEATS - 1));
    assign pop       = wide_valid && wide_ready;

    // Shifting new beats in from the top leaves beat 0 in the low bits once
    // all BEATS beats have arrived.
    assign assembled = LSB_FIRST ? {narrow_data, shift_q[W-1:P]}
                                 : {shift_q[W-P-1:0], narrow_data};

    always_comb begin
        rx_en_d         = 1'b1;
        beat_cnt_d      = beat_cnt_q;
        shift_d         = shift_q;
        credit_return_d = pop;
        overflow_err_d  = overflow_err_q | (last_beat && buf_full && !pop);
        if (beat_acc) begin
            shift_d    = assembled;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_en_q         <= 1'b0;
            beat_cnt_q      <= '0;
            shift_q         <= '0;
            credit_return_q <= 1'b0;
            overflow_err_q  <= 1'b0;
        end else begin
            rx_en_q         <= rx_en_d;
            beat_cnt_q      <= beat_cnt_d;
            shift_q         <= shift_d;
            credit_return_q <= credit_return_d;
            overflow_err_q  <= overflow_err_d;
        end
    end

`ifdef HUB_LINK_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Even parity: the parity bit equals the XOR of the data bits. A bad beat
    // is still assembled so the word count, and thus credits, stay aligned.
    always_comb begin
        parity_err_d = parity_err_q | (beat_acc && ((^narrow_data) != narrow_parity));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_err_q <= 1'b0;
        else          parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    hub_link_rx_buf #(
        .WIDTH (W),
        .DEPTH (CREDITS)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (last_beat),
        .push_data (assembled),
        .pop       (pop),
        .head_data (wide_data),
        .full      (buf_full),
        .count     (buf_count)
    );

    assign wide_valid    = (buf_count != '0);
    assign credit_return = credit_return_q;
    assign overflow_err  = overflow_err_q;

endmodule

// File: doc/hub_link_rx.md
# hub_link_rx

Receive end of the credit-based narrow hub link. Accepts HUB_FIFO_PHYSICAL_WIDTH-bit beats from the physical channel and reassembles them into HUB_FIFO_WIDTH-bit hub words. Completed words go into a CREDITS-deep buffer. The block returns one credit to the transmitter for each word the consumer drains. It sits between the physical narrow channel and the hub's wide input FIFO, replacing ready-based backpressure on the narrow side with credits.

## Interface
Parameters:
- HUB_FIFO_WIDTH, 32: wide word width; must be an integer multiple of HUB_FIFO_PHYSICAL_WIDTH.
- HUB_FIFO_PHYSICAL_WIDTH, 4: narrow beat width.
- CREDITS, 4: receive buffer depth; equals the transmitter's initial credit count; power of two ≥ 2.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- narrow_valid  in  1  beat present this cycle; no ready, so the block must always accept.
- narrow_data  in  HUB_FIFO_PHYSICAL_WIDTH  beat payload.
- narrow_parity  in  1  even parity over narrow_data; port exists only with HUB_LINK_PARITY_EN.
- wide_valid  out  1  buffer non-empty.
- wide_ready  in  1  consumer accepts the head word.
- wide_data  out  HUB_FIFO_WIDTH  head word (first-word fall-through).
- credit_return  out  1  one-cycle pulse, one per drained word.
- overflow_err  out  1  sticky; a word completed while the buffer was full.
- parity_err  out  1  sticky; tied 0 without HUB_LINK_PARITY_EN.

## Operation
- BEATS = HUB_FIFO_WIDTH / HUB_FIFO_PHYSICAL_WIDTH.
- Beat order is least-significant first: beat k fills bits [k*P +: P].
- beat_cnt is a counter over 0..BEATS-1. It increments on each narrow_valid and wraps to 0 on the last beat.
- Beat shift register: on the last beat, the assembled word (last beat included) is pushed into the buffer.
- Gaps: narrow_valid low simply holds state. There is no timeout.
- Buffer is a FWFT FIFO of CREDITS entries.
  - Pop occurs on wide_valid && wide_ready.
  - Push and pop in the same cycle are both legal, including when full. The occupancy count is unchanged.
- Overflow: a push when the buffer is full with no simultaneous pop drops the word. overflow_err is set and the buffer contents are untouched.
- Credit: each pop registers credit_return = 1 for exactly the next cycle. Back-to-back pops give back-to-back pulses.
- Reset (async assert, any time, including mid-word):
  - State: beat_cnt, shift register and buffer pointers cleared, so a partial word is discarded.
  - Outputs: wide_valid 0, wide_data 0, credit_return 0, overflow_err 0, parity_err 0.
  - Reset deassertion is synchronized internally; the first beat is accepted on the second clk edge after release.

## Timing
- Last beat at edge N → wide_valid = 1 after edge N, with wide_data stable.
- Pop at edge M → credit_return high from edge M to edge M+1.
- Minimum word-to-word period is BEATS cycles. Sustained throughput is 1 beat/cycle when the consumer holds wide_ready high.
- Error flags update on the same edge as the offending beat or push. They clear only on reset.

## Configuration
- HUB_LINK_PARITY_EN defined:
  - The narrow_parity port exists and is checked on every accepted beat.
  - On a mismatch, parity_err is set, and the containing word is still delivered unchanged. Data is not dropped, so credit accounting stays aligned.
- HUB_LINK_PARITY_EN undefined: no narrow_parity port and no check logic; parity_err is tied 0.

## Structure
- Shared package hub_link_pkg holds:
  - the BEATS derivation function;
  - the beat-order constant (LSB_FIRST);
  - a typedef for the credit counter width, $clog2(CREDITS)+1, shared with the transmit side's credit counter.
- One sub-module: hub_link_rx_buf, the CREDITS-deep FWFT buffer with full/empty/count. The assembler and credit logic stay in the top module.

## Test plan
- Single word: beats 8,7,6,5,4,3,2,1 on consecutive cycles → wide_data = 32'h12345678, wide_valid high one cycle after the 8th beat. Pop → exactly one credit_return pulse.
- Gapped beats: 32'h9abcdef0 with narrow_valid low for 3 cycles between beats 3 and 4 → word identical. No credit before the pop.
- Fill and overflow: wide_ready = 0, send 5 words (CREDITS = 4) → 4 retained in order, the 5th dropped, overflow_err = 1. Draining yields 4 words and 4 credit pulses.
- Full with simultaneous push/pop: buffer full and wide_ready = 1 on the cycle the last beat of the next word arrives → no overflow, count stays 4, order preserved.
- Reset mid-word: assert reset_n low after 3 beats of 32'h11223344, release, then send 32'h55667788 → only 32'h55667788 is delivered. All outputs are 0 during reset.
- With HUB_LINK_PARITY_EN: corrupt the parity of beat 2 of 32'h99aabbcc → parity_err = 1, word still delivered as 32'h99aabbcc.
